// File: rtl/hamming_pkg.sv
// Shared SECDED helpers: parity-count sizing, data-to-position map, mode encoding.
// Pure constants and constant functions; no logic, latency or backpressure of its own.
package hamming_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int calc_p(input int data_w);
        int p;
        p = 0;
        for (int i = 1; i < 16; i++) begin
            if (p == 0 && (1 << i) >= data_w + i + 1) p = i;
        end
        return p;
    endfunction

    // Position 0 counts as a power of two so it is never taken by data.
    function automatic bit is_pow2(input int x);
        return (x & (x - 1)) == 0;
    endfunction

    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < 256; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j && pos == 0) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic int data_idx(input int pos);
        int cnt;
        cnt = 0;
        for (int i = 3; i < pos; i++) begin
            if (!is_pow2(i)) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Hamming syndrome (XOR of indices of set bits 1..CODE_W-1) and overall parity of a word.
// Purely combinational, zero latency; no handshake, never stalls.
module hamming_syndrome #(
    parameter int CODE_W = 8,
    parameter int P      = 3
) (
    input  logic [CODE_W-1:0] i_word,
    output logic [P-1:0]      o_syn,
    output logic              o_par
);

    // Mask of positions whose index has bit k set; position 0 never contributes.
    function automatic logic [CODE_W-1:0] pos_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (((i >> k) & 1) != 0) m = m | (CODE_W'(1) << i);
        end
        return m;
    endfunction

    for (genvar k = 0; k < P; k++) begin : g_syn
        assign o_syn[k] = ^(i_word & pos_mask(k));
    end

    assign o_par = ^i_word;

endmodule

// File: rtl/hamming_secded_codec.sv
// Pipelined SECDED encode/decode with per-word mode and saturating error counters; HAMMING_ERRINJ_EN adds encode-side bit injection.
// Latency 2 cycles (stage 1: syndrome/encode, stage 2: correction and flags), 1 word/cycle.
// Global stall: both stages hold while out_valid && !out_ready; in_ready follows the same advance.
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter int  DATA_W  = 4,
    parameter int  COUNT_W = 16,
    localparam int P       = calc_p(DATA_W),
    localparam int CODE_W  = DATA_W + P + 1,
    localparam int POS_W   = $clog2(CODE_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [CODE_W-1:0]  in_word,
`ifdef HAMMING_ERRINJ_EN
    input  logic               in_inj,
    input  logic [POS_W-1:0]   in_inj_pos,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [CODE_W-1:0]  out_code,
    output logic [DATA_W-1:0]  out_data,
    output logic               err_single,
    output logic               err_double,
    output logic [POS_W-1:0]   err_pos,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] cnt_single,
    output logic [COUNT_W-1:0] cnt_double
);

    logic              w_advance;
    logic [CODE_W-1:0] w_placed, w_enc, w_syn_in, w_inj_mask;
    logic [P-1:0]      w_syn;
    logic              w_par;

    logic              r1_vld, r1_mode, r1_par;
    logic [CODE_W-1:0] r1_word;
    logic [P-1:0]      r1_syn;
    logic [DATA_W-1:0] r1_data;

    logic              w_dec, w_single, w_double, w_xfer;
    logic [CODE_W-1:0] w_fix, w_corr;
    logic [DATA_W-1:0] w_dat;

    logic               r2_vld, r2_mode, r2_single, r2_double;
    logic [CODE_W-1:0]  r2_code;
    logic [DATA_W-1:0]  r2_data;
    logic [POS_W-1:0]   r2_pos;
    logic [COUNT_W-1:0] r_cnt_single, r_cnt_double;

    assign w_advance = !r2_vld || out_ready;
    assign in_ready  = w_advance;

    // Payload spread into data slots with parity slots zero, so the syndrome of this word is the parity.
    for (genvar pos = 0; pos < CODE_W; pos++) begin : g_place
        if (is_pow2(pos)) begin : g_par_slot
            assign w_placed[pos] = 1'b0;
        end else begin : g_dat_slot
            assign w_placed[pos] = in_word[data_idx(pos)];
        end
    end

    assign w_syn_in = (in_mode == MODE_DEC) ? in_word : w_placed;

    hamming_syndrome #(
        .CODE_W (CODE_W),
        .P      (P)
    ) u_syndrome (
        .i_word (w_syn_in),
        .o_syn  (w_syn),
        .o_par  (w_par)
    );

    for (genvar pos = 0; pos < CODE_W; pos++) begin : g_enc
        if (pos == 0) begin : g_overall
            assign w_enc[pos] = w_par ^ (^w_syn);
        end else if (is_pow2(pos)) begin : g_parity
            assign w_enc[pos] = w_syn[$clog2(pos)];
        end else begin : g_data
            assign w_enc[pos] = w_placed[pos];
        end
    end

`ifdef HAMMING_ERRINJ_EN
    assign w_inj_mask = in_inj ? (CODE_W'(1) << in_inj_pos) : '0;
`else
    assign w_inj_mask = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld  <= 1'b0;
            r1_mode <= 1'b0;
            r1_par  <= 1'b0;
            r1_syn  <= '0;
            r1_word <= '0;
            r1_data <= '0;
        end else if (w_advance) begin
            r1_vld  <= in_valid;
            r1_mode <= in_mode;
            r1_par  <= w_par;
            r1_syn  <= w_syn;
            r1_word <= (in_mode == MODE_DEC) ? in_word : (w_enc ^ w_inj_mask);
            r1_data <= in_word[DATA_W-1:0];
        end
    end

    // Odd overall parity means one flipped bit at index s (s == 0 is the overall parity bit itself).
    assign w_dec    = (r1_mode == MODE_DEC);
    assign w_single = w_dec && r1_par;
    assign w_double = w_dec && !r1_par && (r1_syn != '0);
    assign w_fix    = w_single ? (CODE_W'(1) << r1_syn) : '0;
    assign w_corr   = r1_word ^ w_fix;

    for (genvar g = 0; g < DATA_W; g++) begin : g_extract
        assign w_dat[g] = w_corr[data_pos(g)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_vld    <= 1'b0;
            r2_mode   <= 1'b0;
            r2_code   <= '0;
            r2_data   <= '0;
            r2_single <= 1'b0;
            r2_double <= 1'b0;
            r2_pos    <= '0;
        end else if (w_advance) begin
            r2_vld    <= r1_vld;
            r2_mode   <= r1_mode;
            r2_code   <= w_corr;
            r2_data   <= w_dec ? w_dat : r1_data;
            r2_single <= r1_vld && w_single;
            r2_double <= r1_vld && w_double;
            r2_pos    <= (r1_vld && w_single) ? POS_W'(r1_syn) : '0;
        end
    end

    assign w_xfer = r2_vld && out_ready && (r2_mode == MODE_DEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (cnt_clr) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else begin
            if (w_xfer && r2_single && r_cnt_single != '1) r_cnt_single <= r_cnt_single + COUNT_W'(1);
            if (w_xfer && r2_double && r_cnt_double != '1) r_cnt_double <= r_cnt_double + COUNT_W'(1);
        end
    end

    assign out_valid  = r2_vld;
    assign out_mode   = r2_mode;
    assign out_code   = r2_code;
    assign out_data   = r2_data;
    assign err_single = r2_single;
    assign err_double = r2_double;
    assign err_pos    = r2_pos;
    assign cnt_single = r_cnt_single;
    assign cnt_double = r_cnt_double;

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
- Parametrised, pipelined Hamming SECDED encoder/decoder; successor to the combinational Hamming(7,4) top.
- A per-transaction mode bit selects encode or decode, replacing the static selector.
- Valid/ready streaming interface, 2-cycle latency, saturating error statistics.
- Sits between the switch/data source and the LED/display or link logic.

Parameters:
- DATA_W, 4, payload width; legal values are 4, 11, 26, 57.
- P (localparam), derived, Hamming parity bit count; smallest P with 2^P >= DATA_W+P+1.
- CODE_W (localparam), DATA_W+P+1, SECDED codeword width.
- COUNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_mode  in  1  0 = encode, 1 = decode
- in_word  in  CODE_W  encode: payload in [DATA_W-1:0], upper bits ignored; decode: received codeword
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_mode  out  1  mode of the transaction being presented
- out_code  out  CODE_W  encode: generated codeword; decode: corrected codeword
- out_data  out  DATA_W  decode: corrected payload; encode: echo of the payload
- err_single  out  1  decode: single-bit error corrected
- err_double  out  1  decode: uncorrectable double error
- err_pos  out  $clog2(CODE_W)  decode: index of the corrected bit; 0 when no single error
- cnt_clr  in  1  synchronous clear of both counters
- cnt_single  out  COUNT_W  saturating count of corrected words
- cnt_double  out  COUNT_W  saturating count of double-error words

Behaviour:
- Codeword layout: bit i = Hamming position i. Parity bits at power-of-two positions. Bit 0 = overall even parity over bits [CODE_W-1:1]. Data bits fill the remaining positions in ascending order, data LSB first.
- Encode: each parity bit at position 2^k = XOR of all positions with bit k set. Overall parity is computed last.
- Decode:
  - Syndrome s = XOR of the indices of all set bits in [CODE_W-1:1]; o = XOR of all CODE_W bits.
  - s==0, o==0: clean.
  - o==1: single error at position s (s==0 means bit 0). Flip that bit, err_single=1, err_pos=s.
  - s!=0, o==0: err_double=1. out_code and out_data are passed uncorrected; err_pos=0.
- Pipeline:
  - Stage 1 registers mode, word and the syndrome/parity (or the encoded word). Stage 2 registers the corrected result and flags.
  - Latency: exactly 2 cycles from the in_valid&&in_ready edge to out_valid when out_ready=1.
  - Global stall: advance = !out_valid || out_ready; in_ready = advance. Bubbles propagate.
  - Full throughput of 1 word per cycle.
- While out_valid=1 and out_ready=0, every out_* signal is held stable.
- Counters increment on the out_valid&&out_ready handshake of a decode result with the matching flag set. They saturate at all-ones.
- cnt_clr has priority over a simultaneous increment.
- Reset (async, also mid-transfer): both pipeline stages flushed, out_valid=0, every output data and flag = 0, counters = 0. in_ready=1 from the first clock after reset release.

Optional Feature:
- HAMMING_ERRINJ_EN defined: adds inputs in_inj (1) and in_inj_pos ($clog2(CODE_W)), captured with each encode transaction. When in_inj=1, bit in_inj_pos of out_code is inverted after encoding. Positions >= CODE_W inject nothing. Decode is unaffected.
- Undefined: these ports and the injection logic do not exist; encode output is always clean.

Decomposition:
- Package hamming_pkg: function for P from DATA_W; function for the data-to-position map; mode encoding constants MODE_ENC=0, MODE_DEC=1.
- One sub-module, hamming_syndrome: combinational, computes s and o from a CODE_W word. Reused for encode parity generation with the parity slots zeroed.

Test Plan:
- Encode, DATA_W=4, in_word=4'b1010 -> out_code=8'hA5, out_valid exactly 2 cycles after acceptance, no flags.
- Decode 8'hA5 -> out_data=4'b1010, err_single=0, err_double=0, counters unchanged.
- Decode 8'h85 (bit 5 flipped) -> out_code=8'hA5, out_data=4'b1010, err_single=1, err_pos=5, cnt_single=1. Repeat for 8'hA4 (bit 0 flipped) -> err_pos=0, err_single=1.
- Decode 8'h81 (bits 5 and 2 flipped) -> err_double=1, out_code=8'h81, cnt_double=1.
- Back-to-back 4 transactions with out_ready low for 3 cycles mid-stream -> outputs held stable, in_ready=0 while stalled, no loss or duplication, order preserved. Assert rst_n mid-stream -> out_valid=0 immediately, counters=0.
- With HAMMING_ERRINJ_EN: encode 4'b1010, in_inj=1, in_inj_pos=3 -> out_code=8'hAD. Feed it back for decode -> err_pos=3, out_data=4'b1010.
